// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - shared state type and lamp-pattern helpers for tail_light_seq
package tail_light_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_e;

  // Patterns are built at a fixed maximum width and truncated by the user to N_LAMPS.
  localparam int MAX_LAMPS = 32;

  function automatic int step_w(input int n_lamps);
    return $clog2(n_lamps + 1);
  endfunction

  function automatic logic [MAX_LAMPS-1:0] fill_lsb(input int k);
    logic [MAX_LAMPS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (i < k) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [MAX_LAMPS-1:0] fill_msb(input int k, input int n_lamps);
    logic [MAX_LAMPS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (i < n_lamps && i >= n_lamps - k) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/tail_light_seq_prescaler.sv
// rtl/tail_light_seq_prescaler.sv - step-rate prescaler, one pulse every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic step_pulse
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step_pulse = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || step_pulse) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - sequential turn/hazard/brake tail-light controller
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  input  logic               brake,
  output logic [N_LAMPS-1:0] tl,
  output logic [N_LAMPS-1:0] tr,
  output logic               busy
);

  localparam int STEP_W = step_w(N_LAMPS);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_LAMPS);

  state_e              state_q, state_d, eff;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [N_LAMPS-1:0]  tl_q, tl_d, tr_q, tr_d;
  logic                busy_q, busy_d;
  logic                step_pulse, clr;

  // The prescaler restarts on every state entry and is held clear while idle.
  assign clr = (state_q == IDLE) || (state_d != state_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .step_pulse (step_pulse)
  );

  always_comb begin
    eff = IDLE;
    if (hazard || (left && right)) eff = HAZARD;
    else if (left)                 eff = LEFT;
    else if (right)                eff = RIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      tl_q    <= '0;
      tr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tl_q    <= tl_d;
      tr_q    <= tr_d;
      busy_q  <= busy_d;
    end
  end

  // Only hazard preempts; everything else is re-evaluated at the wrap.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        state_d = eff;
        step_d  = '0;
      end
      default: begin
        if (hazard && state_q != HAZARD) begin
          state_d = HAZARD;
          step_d  = '0;
        end else if (step_pulse) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            state_d = eff;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    tl_d   = brake ? '1 : '0;
    tr_d   = brake ? '1 : '0;
    busy_d = (state_d != IDLE);
    case (state_d)
      LEFT:   tl_d = N_LAMPS'(fill_msb(int'(step_d), N_LAMPS));
      RIGHT:  tr_d = N_LAMPS'(fill_lsb(int'(step_d)));
      HAZARD: begin
        tl_d = N_LAMPS'(fill_msb(int'(step_d), N_LAMPS));
        tr_d = N_LAMPS'(fill_lsb(int'(step_d)));
      end
      default: ;
    endcase
  end

  assign tl   = tl_q;
  assign tr   = tr_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// tb/tb_tail_light_seq.sv - directed vector bench for tail_light_seq
module tb_tail_light_seq;

  logic clk;
  logic rst_n, left, right, hazard, brake;
  logic [2:0] tl, tr;
  logic busy;
  logic rst_n_b, right_b;
  logic [4:0] tl_b, tr_b;
  logic busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst_n, l, r, h, b;
    logic [2:0] tl, tr;
    logic       busy;
    int         n;
  } vec_t;

  vec_t vecs[$];

  tail_light_seq #(.N_LAMPS(3), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .tl(tl), .tr(tr), .busy(busy)
  );

  tail_light_seq #(.N_LAMPS(5), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .left(1'b0), .right(right_b), .hazard(1'b0),
    .brake(1'b0), .tl(tl_b), .tr(tr_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic add(input logic r_n, l, r, h, b, input logic [2:0] etl, etr,
                     input logic ebusy, input int n);
    vec_t v;
    v.rst_n = r_n; v.l = l; v.r = r; v.h = h; v.b = b;
    v.tl = etl; v.tr = etr; v.busy = ebusy; v.n = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] exp_b [8];

    rst_n = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    rst_n_b = 1'b0; right_b = 1'b0;

    //  rst l  r  h  b   tl      tr      busy n
    add(0, 1, 0, 0, 0, 3'b000, 3'b000, 0, 2);
    add(1, 1, 0, 0, 0, 3'b000, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b100, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b110, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b111, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b000, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b100, 3'b000, 1, 4);
    add(1, 0, 0, 0, 0, 3'b110, 3'b000, 1, 4);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, 1, 4);
    add(1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 2);
    add(1, 0, 0, 0, 1, 3'b111, 3'b111, 0, 2);
    add(1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
    add(1, 0, 1, 0, 0, 3'b000, 3'b000, 1, 1);
    add(1, 0, 0, 0, 0, 3'b000, 3'b000, 1, 3);
    add(1, 0, 0, 0, 0, 3'b000, 3'b001, 1, 4);
    add(1, 0, 0, 0, 0, 3'b000, 3'b011, 1, 4);
    add(1, 0, 0, 0, 0, 3'b000, 3'b111, 1, 4);
    add(1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 2);
    add(1, 1, 0, 0, 1, 3'b000, 3'b111, 1, 4);
    add(1, 1, 0, 0, 1, 3'b100, 3'b111, 1, 4);
    add(1, 1, 0, 0, 0, 3'b110, 3'b000, 1, 1);
    add(1, 1, 0, 1, 0, 3'b000, 3'b000, 1, 4);
    add(1, 1, 0, 1, 0, 3'b100, 3'b001, 1, 4);
    add(1, 1, 0, 1, 1, 3'b110, 3'b011, 1, 4);
    add(1, 1, 0, 1, 0, 3'b111, 3'b111, 1, 4);
    add(1, 1, 0, 1, 0, 3'b000, 3'b000, 1, 4);
    add(1, 0, 0, 0, 0, 3'b100, 3'b001, 1, 4);
    add(1, 0, 0, 0, 0, 3'b110, 3'b011, 1, 4);
    add(1, 0, 0, 0, 0, 3'b111, 3'b111, 1, 4);
    add(1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
    add(1, 1, 1, 0, 0, 3'b000, 3'b000, 1, 4);
    add(1, 1, 1, 0, 0, 3'b100, 3'b001, 1, 4);
    add(1, 1, 0, 0, 0, 3'b110, 3'b011, 1, 4);
    add(1, 1, 0, 0, 0, 3'b111, 3'b111, 1, 4);
    add(1, 1, 0, 0, 0, 3'b000, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b100, 3'b000, 1, 4);
    add(1, 1, 0, 0, 0, 3'b110, 3'b000, 1, 1);
    add(1, 0, 1, 0, 0, 3'b110, 3'b000, 1, 3);
    add(1, 0, 1, 0, 0, 3'b111, 3'b000, 1, 4);
    add(1, 0, 1, 0, 0, 3'b000, 3'b000, 1, 4);
    add(1, 0, 1, 0, 0, 3'b000, 3'b001, 1, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; left = vecs[i].l; right = vecs[i].r;
      hazard = vecs[i].h; brake = vecs[i].b;
      for (int c = 0; c < vecs[i].n; c++) begin
        @(posedge clk); #1;
        check($sformatf("vec%0d.%0d tl", i, c), 32'(tl), 32'(vecs[i].tl));
        check($sformatf("vec%0d.%0d tr", i, c), 32'(tr), 32'(vecs[i].tr));
        check($sformatf("vec%0d.%0d busy", i, c), 32'(busy), 32'(vecs[i].busy));
      end
    end

    // Hazard preempts RIGHT mid-step, then an asynchronous reset lands between edges.
    right = 1'b0; hazard = 1'b1;
    @(posedge clk); #1;
    check("preempt tl", 32'(tl), 32'b000);
    check("preempt tr", 32'(tr), 32'b000);
    check("preempt busy", 32'(busy), 32'b1);
    repeat (4) @(posedge clk);
    #1;
    check("hazard step1 tl", 32'(tl), 32'b100);
    check("hazard step1 tr", 32'(tr), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    check("async rst tl", 32'(tl), 32'b000);
    check("async rst tr", 32'(tr), 32'b000);
    check("async rst busy", 32'(busy), 32'b0);
    @(posedge clk); #1;
    check("rst held busy", 32'(busy), 32'b0);
    hazard = 1'b0;

    // N_LAMPS=5, TICK_DIV=1: right steps once per cycle.
    exp_b[0] = 5'b00000; exp_b[1] = 5'b00001; exp_b[2] = 5'b00011; exp_b[3] = 5'b00111;
    exp_b[4] = 5'b01111; exp_b[5] = 5'b11111; exp_b[6] = 5'b00000; exp_b[7] = 5'b00001;
    right_b = 1'b1;
    @(posedge clk); #1;
    check("b reset tr", 32'(tr_b), 32'b0);
    check("b reset busy", 32'(busy_b), 32'b0);
    rst_n_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("b step%0d tr", k), 32'(tr_b), 32'(exp_b[k]));
      check($sformatf("b step%0d tl", k), 32'(tl_b), 32'b0);
      check($sformatf("b step%0d busy", k), 32'(busy_b), 32'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
